// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for a small 8-bit core.
// It drives the fetch, register-file and data-memory handshakes. Every control output is registered.
module multicycle_ctrl #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        instr_req,
    output logic [7:0]  instr_addr,
    input  logic        instr_ack,
    input  logic [8:0]  instr_in,
    output logic [2:0]  alu_op,
    output logic [2:0]  reg_a_addr,
    output logic [2:0]  reg_b_addr,
    input  logic [7:0]  reg_b_data,
    input  logic        alu_jump_flag,
    output logic        reg_we,
    output logic [2:0]  reg_w_addr,
    output logic        wb_sel,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        busy,
    output logic        halted,
    output logic        error,
    output logic [15:0] instr_count
);
    localparam logic [2:0] OP_LD     = 3'd5;
    localparam logic [2:0] OP_ST     = 3'd6;
    localparam logic [2:0] OP_BLQZ   = 3'd7;
    localparam logic [8:0] HALT_WORD = 9'h1FF;
    localparam int         WW        = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    typedef struct packed {
        logic       instr_req;
        logic       mem_req;
        logic       mem_we;
        logic       reg_we;
        logic       wb_sel;
        logic       busy;
        logic       halted;
        logic       error;
        logic [2:0] alu_op;
        logic [2:0] ra;
        logic [2:0] rb;
    } outs_t;

    state_t        state_q, state_d;
    logic [7:0]    pc_q, pc_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [8:0]    instr_q, instr_d;
    logic [WW-1:0] wait_q, wait_d;
    outs_t         out_q, out_d;

    // Outputs are decoded from the next state so that they line up with the state they describe.
    function automatic outs_t outs_for(input state_t s, input logic [8:0] w);
        outs_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.instr_req = 1'b1;
                o.busy      = 1'b1;
            end
            S_DECODE, S_EXEC, S_MEM, S_WB: begin
                o.busy   = 1'b1;
                o.alu_op = w[8:6];
                o.ra     = w[5:3];
                o.rb     = w[2:0];
                o.mem_req = (s == S_MEM);
                o.mem_we  = (s == S_MEM) && (w[8:6] == OP_ST);
                o.reg_we  = (s == S_WB);
                o.wb_sel  = (s == S_WB) && (w[8:6] == OP_LD);
            end
            S_HALT:  o.halted = 1'b1;
            S_ERR:   o.error  = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                if (instr_ack) begin
                    instr_d = instr_in;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: state_d = (instr_q == HALT_WORD) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (instr_q[8:6])
                    OP_LD, OP_ST: state_d = S_MEM;
                    OP_BLQZ: begin
                        pc_d    = alu_jump_flag ? reg_b_data : pc_q + 8'd1;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (instr_q[8:6] == OP_ST) begin
                        pc_d    = pc_q + 8'd1;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                pc_d    = pc_q + 8'd1;
                cnt_d   = cnt_q + 16'd1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        // The wait count restarts whenever a state is entered.
        wait_d = '0;
        if (state_d == state_q && (state_q == S_FETCH || state_q == S_MEM))
            wait_d = wait_q + 1'b1;

        out_d = outs_for(state_d, instr_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            instr_q <= '0;
            wait_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            out_q   <= out_d;
        end
    end

    assign instr_req   = out_q.instr_req;
    assign instr_addr  = pc_q;
    assign alu_op      = out_q.alu_op;
    assign reg_a_addr  = out_q.ra;
    assign reg_b_addr  = out_q.rb;
    assign reg_w_addr  = out_q.ra;
    assign reg_we      = out_q.reg_we;
    assign wb_sel      = out_q.wb_sel;
    assign mem_req     = out_q.mem_req;
    assign mem_we      = out_q.mem_we;
    assign busy        = out_q.busy;
    assign halted      = out_q.halted;
    assign error       = out_q.error;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: it plays the instruction/data memories and runs directed and random programs.
// PC and retire count come from a per-instruction model.
module tb_multicycle_ctrl;
    localparam logic [7:0] RPC = 8'h00;
    localparam int MAXW = 15;
    localparam logic [2:0] OP_ADD = 3'd0, OP_LD = 3'd5, OP_ST = 3'd6, OP_BLQZ = 3'd7;

    logic        clk = 1'b0;
    logic        reset, start, instr_ack, alu_jump_flag, mem_ack;
    logic [8:0]  instr_in;
    logic [7:0]  reg_b_data;
    logic        instr_req, reg_we, wb_sel, mem_req, mem_we, busy, halted, error;
    logic [7:0]  instr_addr;
    logic [2:0]  alu_op, reg_a_addr, reg_b_addr, reg_w_addr;
    logic [15:0] instr_count;

    int total = 0;
    int bad   = 0;
    logic [7:0]  m_pc;
    logic [15:0] m_cnt;

    multicycle_ctrl #(.RESET_PC(RPC), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_in(instr_in),
        .alu_op(alu_op), .reg_a_addr(reg_a_addr), .reg_b_addr(reg_b_addr),
        .reg_b_data(reg_b_data), .alu_jump_flag(alu_jump_flag),
        .reg_we(reg_we), .reg_w_addr(reg_w_addr), .wb_sel(wb_sel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .busy(busy), .halted(halted), .error(error), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_pc  = RPC;
        m_cnt = '0;
        chk("start_req", instr_req, 1);
        chk("start_addr", instr_addr, m_pc);
        chk("start_cnt", instr_count, 0);
        chk("start_flags", {busy, halted, error}, 3'b100);
    endtask

    // Run one instruction from FETCH back to the next FETCH (or into HALT).
    task automatic run_instr(input logic [8:0] word, input int fd, input int md,
                             input logic flag, input logic [7:0] bd);
        logic [2:0] op, ra, rb;
        op = word[8:6]; ra = word[5:3]; rb = word[2:0];
        for (int i = 0; i < fd; i++) begin
            chk("fetch_hold", {instr_req, busy}, 2'b11);
            instr_ack = 1'b0;
            step();
        end
        chk("fetch_addr", instr_addr, m_pc);
        chk("fetch_req", instr_req, 1);
        chk("fetch_alu_op", alu_op, 0);
        instr_ack = 1'b1;
        instr_in  = word;
        step();
        instr_ack = 1'b0;
        instr_in  = 9'($urandom);
        chk("dec_fields", {alu_op, reg_a_addr, reg_b_addr}, {op, ra, rb});
        chk("dec_req", {instr_req, mem_req, reg_we, busy}, 4'b0001);
        if (word == 9'h1FF) begin
            step();
            chk("halt_flags", {busy, halted, error}, 3'b010);
            chk("halt_pc", instr_addr, m_pc);
            chk("halt_cnt", instr_count, m_cnt);
            chk("halt_alu_op", alu_op, 0);
            return;
        end
        // Stray start/acks here must be ignored.
        alu_jump_flag = flag;
        reg_b_data    = bd;
        start         = 1'($urandom_range(0, 1));
        instr_ack     = 1'($urandom_range(0, 1));
        mem_ack       = 1'($urandom_range(0, 1));
        step();
        start = 1'b0; instr_ack = 1'b0; mem_ack = 1'b0;
        chk("exec_fields", {alu_op, reg_a_addr, reg_b_addr}, {op, ra, rb});
        chk("exec_ctl", {instr_req, mem_req, reg_we, busy}, 4'b0001);
        if (op == OP_BLQZ) begin
            step();
            m_pc = flag ? bd : m_pc + 8'd1;
            m_cnt++;
        end else if (op == OP_LD || op == OP_ST) begin
            step();
            for (int i = 0; i < md; i++) begin
                chk("mem_hold", {mem_req, mem_we, reg_we}, {1'b1, op == OP_ST, 1'b0});
                chk("mem_alu_op", alu_op, op);
                step();
            end
            chk("mem_ack_cyc", {mem_req, mem_we}, {1'b1, op == OP_ST});
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            if (op == OP_LD) begin
                chk("ld_wb", {reg_we, wb_sel, mem_req}, 3'b110);
                chk("ld_waddr", reg_w_addr, ra);
                step();
            end
            m_pc++;
            m_cnt++;
        end else begin
            step();
            chk("alu_wb", {reg_we, wb_sel, mem_req}, 3'b100);
            chk("alu_waddr", reg_w_addr, ra);
            chk("wb_alu_op", alu_op, op);
            step();
            m_pc++;
            m_cnt++;
        end
        chk("next_req", {instr_req, reg_we, mem_req}, 3'b100);
        chk("next_addr", instr_addr, m_pc);
        chk("next_cnt", instr_count, m_cnt);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instr_ack = 1'b0; mem_ack = 1'b0;
        instr_in = '0; alu_jump_flag = 1'b0; reg_b_data = '0;
        step(); step();
        chk("rst_ctl", {instr_req, mem_req, mem_we, reg_we}, 4'b0000);
        chk("rst_flags", {busy, halted, error}, 3'b000);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_pc", instr_addr, RPC);
        chk("rst_cnt", instr_count, 0);
        reset = 1'b0;
        step(); step();
        chk("idle_no_start", {instr_req, busy}, 2'b00);

        do_start();
        run_instr({OP_ADD, 3'd1, 3'd2}, 0, 0, 1'b0, 8'h00);
        chk("add_pc1", instr_addr, 8'h01);
        run_instr({OP_LD, 3'd3, 3'd4}, 0, 3, 1'b0, 8'h00);
        run_instr({OP_ST, 3'd5, 3'd6}, 1, 2, 1'b0, 8'h00);
        run_instr({OP_BLQZ, 3'd0, 3'd1}, 0, 0, 1'b1, 8'h20);
        chk("blqz_taken", instr_addr, 8'h20);
        run_instr({OP_BLQZ, 3'd0, 3'd1}, 0, 0, 1'b0, 8'h77);
        chk("blqz_not_taken", instr_addr, 8'h21);
        run_instr({OP_BLQZ, 3'd2, 3'd3}, 0, 0, 1'b1, 8'hFF);
        run_instr({OP_ADD, 3'd1, 3'd1}, 0, 0, 1'b0, 8'h00);
        chk("pc_wrap", instr_addr, 8'h00);
        run_instr({3'd1, 3'd7, 3'd0}, MAXW - 1, 0, 1'b0, 8'h00);
        run_instr({OP_LD, 3'd2, 3'd2}, 0, MAXW - 1, 1'b0, 8'h00);

        for (int n = 0; n < 60; n++) begin
            logic [8:0] w;
            int fd;
            do w = 9'($urandom); while (w == 9'h1FF);
            fd = ($urandom_range(0, 7) == 0) ? MAXW - 1 : int'($urandom_range(0, 3));
            run_instr(w, fd, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        run_instr(9'h1FF, 0, 0, 1'b0, 8'h00);
        step(); step(); step();
        chk("halt_hold", {halted, busy, instr_req}, 3'b100);
        chk("halt_pc_frozen", instr_addr, m_pc);
        chk("halt_cnt_frozen", instr_count, m_cnt);
        do_start();

        for (int i = 0; i < MAXW - 1; i++) step();
        chk("fetch_wait_last", {instr_req, error}, 2'b10);
        step();
        chk("timeout_err", {error, instr_req, busy, halted}, 4'b1000);
        chk("timeout_pc", instr_addr, m_pc);
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        chk("err_ignore_ack", {error, instr_req}, 2'b10);
        do_start();

        run_instr({OP_ADD, 3'd4, 3'd4}, 0, 0, 1'b0, 8'h00);
        instr_ack = 1'b1; instr_in = {OP_LD, 3'd1, 3'd2};
        step();
        instr_ack = 1'b0;
        step(); step();
        chk("pre_rst_mem", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("rst_mem_req", {mem_req, reg_we, busy}, 3'b000);
        chk("rst_mid_alu_op", alu_op, 0);
        chk("rst_mid_cnt", instr_count, 0);
        chk("rst_mid_pc", instr_addr, RPC);
        step();
        reset = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step(); step();
        chk("rst_needs_start", {instr_req, mem_req, reg_we, busy}, 4'b0000);
        do_start();
        run_instr({OP_ST, 3'd0, 3'd0}, 0, 0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset and on every start.
REQ-002 Parameter MAX_WAIT, default 15: maximum wait cycles for instr_ack or mem_ack before an error is raised.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; starts program execution from IDLE, HALT or ERR, and is ignored in all other states.
REQ-006 instr_req  output  1  instruction fetch request.
REQ-007 instr_addr  output  8  fetch address, equal to the PC.
REQ-008 instr_ack  input  1  fetch complete, with instr_in valid in the same cycle.
REQ-009 instr_in  input  9  instruction word: [8:6] opcode, [5:3] ra, [2:0] rb.
REQ-010 alu_op  output  3  opcode driven to the ALU, using the shared definitions-package encoding (ADD, XOR, AND, RSL, MOV, LD, ST, BLQZ).
REQ-011 reg_a_addr, reg_b_addr  output  3 each  register-file read addresses, taken from ra and rb.
REQ-012 reg_b_data  input  8  register rb read data, used as the branch target.
REQ-013 alu_jump_flag  input  1  ALU branch-taken flag.
REQ-014 reg_we  output  1  register-file write enable.
REQ-015 reg_w_addr  output  3  write address, equal to ra.
REQ-016 wb_sel  output  1  write-back source select: 0 = ALU result, 1 = memory read data.
REQ-017 mem_req, mem_we  output  1 each  data-memory request and write enable.
REQ-018 mem_ack  input  1  data-memory access complete.
REQ-019 busy, halted, error  output  1 each  status flags.
REQ-020 instr_count  output  16  count of retired instructions.

Function
REQ-021 The FSM SHALL have exactly these states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
REQ-022 IDLE: on start, load PC = RESET_PC, clear instr_count, and go to FETCH.
REQ-023 FETCH: hold instr_req = 1 and instr_addr = PC until instr_ack; on the ack cycle, latch instr_in and go to DECODE.
REQ-024 DECODE (1 cycle): drive reg_a_addr/reg_b_addr from the latched word and drive alu_op from its opcode field.
REQ-025 DECODE exit: word 9'h1FF is HALT and goes to the HALT state; any other word goes to EXEC.
REQ-026 alu_op, reg_a_addr and reg_b_addr SHALL stay constant from DECODE through the instruction's last state; alu_op is 3'b000 in IDLE, FETCH, HALT and ERR.
REQ-027 EXEC (1 cycle): ADD, XOR, AND, RSL and MOV go to WB with wb_sel = 0.
REQ-028 EXEC: LD goes to MEM with mem_we = 0; ST goes to MEM with mem_we = 1.
REQ-029 EXEC: for BLQZ, sample alu_jump_flag; if 1, PC <= reg_b_data, else PC <= PC+1; retire and go to FETCH.
REQ-030 MEM: hold mem_req = 1 until mem_ack, with mem_we held stable.
REQ-031 MEM exit on mem_ack: LD goes to WB with wb_sel = 1; ST does PC+1, retires and goes to FETCH.
REQ-032 WB (1 cycle): assert reg_we = 1 with reg_w_addr = ra; PC <= PC+1; retire; go to FETCH.
REQ-033 reg_we SHALL be 1 only in WB, and mem_req only in MEM.
REQ-034 PC arithmetic is 8-bit modulo, so 8'hFF+1 = 8'h00; instr_count wraps from 16'hFFFF to 0.
REQ-035 Wait counter: count consecutive cycles in FETCH or MEM without an ack; reset the counter on state entry.
REQ-036 Timeout: when the count reaches MAX_WAIT without an ack, go to ERR and drop the request in the next cycle.
REQ-037 An ack arriving on the same cycle the limit is reached SHALL be accepted, with no error.
REQ-038 HALT: halted = 1; ERR: error = 1; both hold PC and instr_count; start restarts as in IDLE and clears halted/error.
REQ-039 busy = 1 in FETCH, DECODE, EXEC, MEM and WB; busy = 0 otherwise.
REQ-040 instr_ack outside FETCH and mem_ack outside MEM SHALL be ignored.
REQ-041 start while busy SHALL have no effect.

Reset
REQ-042 reset asserted SHALL immediately force state = IDLE, PC = RESET_PC and instr_count = 0.
REQ-043 reset asserted SHALL immediately force all request and enable outputs to 0, alu_op to 0, and busy, halted and error to 0.
REQ-044 Reset mid-operation SHALL abandon any in-flight fetch or memory request with no write-back; operation resumes only on start after reset deasserts.

Verification
REQ-045 ADD r1,r2 with 0-wait acks → instr_req for 1 cycle, then DECODE, EXEC, then WB with reg_we = 1, reg_w_addr = 1; PC 0→1; instr_count = 1; 4 cycles per instruction.
REQ-046 LD with mem_ack after 3 cycles → mem_req high for exactly 4 cycles, then WB with wb_sel = 1; ST → no reg_we, PC+1.
REQ-047 BLQZ with alu_jump_flag = 1 and reg_b_data = 8'h20 → next instr_addr = 8'h20; with flag = 0 → PC+1.
REQ-048 instr_ack withheld for 15 cycles → ERR, error = 1, instr_req = 0; then start → FETCH at RESET_PC with error = 0.
REQ-049 Word 9'h1FF → halted = 1, busy = 0, PC frozen; PC at 8'hFF executing ADD → next fetch at 8'h00.
REQ-050 reset asserted during MEM → mem_req drops to 0 in the same cycle, state = IDLE, and start is required to resume.
